imem_writer: RTL and testbench

Instruction-memory loader for the single-cycle RV32I core: the encoding counterpart to the control unit's decoder. Accepts symbolic instruction requests (kind, register fields, immediate) over a valid/ready handshake. Encodes each into a 32-bit RV32I word and writes it to consecutive word addresses of the instruction memory. Used by benches and the boot path to build programs that the control unit then decodes.

---
 rtl/rv_isa_pkg.sv | 46 ++++
 rtl/instr_encoder.sv | 38 +++
 rtl/imem_writer.sv | 155 +++++++++++++++
 tb/tb_imem_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv_isa_pkg
// Brief    : RV32I opcode/funct constants, request kinds and loader FSM states.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        KIND_LW      = 3'd0,
        KIND_SW      = 3'd1,
        KIND_BEQ     = 3'd2,
        KIND_ADD     = 3'd3,
        KIND_SUB     = 3'd4,
        KIND_AND     = 3'd5,
        KIND_OR      = 3'd6,
        KIND_ILLEGAL = 3'd7
    } kindT;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        CHECK = 3'd2,
        CMP   = 3'd3,
        FULL  = 3'd4
    } wrStateT;

endpackage

`default_nettype wire

// File: rtl/instr_encoder.sv
//------------------------------------------------------------------------------
// Module   : instr_encoder
// Brief    : Combinational symbolic-request to RV32I word encoder with illegal flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_encoder
    import rv_isa_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kindT'(kind))
            KIND_LW:  word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            KIND_SW:  word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            // Branch offsets are in bytes; bit 0 is implicitly zero.
            KIND_BEQ: word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
            KIND_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
            KIND_SUB: word = {F7_SUB, rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
            KIND_AND: word = {F7_BASE, rs2, rs1, F3_AND, rd, OP_RTYPE};
            KIND_OR:  word = {F7_BASE, rs2, rs1, F3_OR, rd, OP_RTYPE};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imem_writer.sv
//------------------------------------------------------------------------------
// Module   : imem_writer
// Brief    : Encodes symbolic RV32I requests and writes them to consecutive
//            instruction-memory words; IMEM_WR_READBACK_EN adds write verify.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_writer
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [12:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              bad_kind,
    output logic              mismatch
);

    localparam logic [ADDR_W:0]   C_CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   C_COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE   = ADDR_W'(1);

    wrStateT           r_state;
    wrStateT           w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_word;
    logic              r_badKind;
    logic [31:0]       w_encWord;
    logic              w_encIllegal;
    logic              w_accept;

    instr_encoder u_encoder (
        .kind    (kind),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .word    (w_encWord),
        .illegal (w_encIllegal)
    );

    assign count    = r_count;
    assign full     = (r_count == C_CAPACITY);
    assign bad_kind = r_badKind;
    // clr wins over a same-cycle request, so it masks acceptance.
    assign w_accept = (r_state == IDLE) && in_valid && !full && !clr;

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = r_ptr;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                in_ready = !full && !clr;
                if (w_accept && !w_encIllegal) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = r_word;
`ifdef IMEM_WR_READBACK_EN
                w_nextState = CHECK;
`else
                w_nextState = ((r_count + C_COUNT_ONE) == C_CAPACITY) ? FULL : IDLE;
`endif
            end
`ifdef IMEM_WR_READBACK_EN
            CHECK: begin
                mem_addr    = r_ptr - C_PTR_ONE;
                w_nextState = CMP;
            end
            CMP: begin
                mem_addr    = r_ptr - C_PTR_ONE;
                w_nextState = full ? FULL : IDLE;
            end
`endif
            FULL:    w_nextState = FULL;
            default: w_nextState = IDLE;
        endcase
        if (clr) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_count   <= '0;
            r_word    <= '0;
            r_badKind <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (clr) begin
                r_ptr     <= '0;
                r_count   <= '0;
                r_badKind <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_encIllegal) begin
                        r_badKind <= 1'b1;
                    end else begin
                        r_word <= w_encWord;
                    end
                end
                if (r_state == WRITE) begin
                    r_ptr <= r_ptr + C_PTR_ONE;
                    if (!full) begin
                        r_count <= r_count + C_COUNT_ONE;
                    end
                end
            end
        end
    end

`ifdef IMEM_WR_READBACK_EN
    logic r_mismatch;

    // Survives clr on purpose: only reset forgets a failed verify.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (!clr && (r_state == CMP) && (mem_rdata != r_word)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    // mem_rdata is referenced but has no effect without readback.
    assign mismatch = 1'b0 & (^mem_rdata);
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_writer.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_writer
// Brief    : Self-checking bench for imem_writer (ADDR_W=2) with a memory model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_writer;

    localparam int AW  = 2;
    localparam int CAP = 4;
`ifdef IMEM_WR_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, clr, in_valid, in_ready;
    logic [2:0]    kind;
    logic [4:0]    rd, rs1, rs2;
    logic [12:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [AW:0]   count;
    logic          full, bad_kind, mismatch;

    logic [31:0]   memArr [CAP];
    logic          corrupt;

    int            total = 0;
    int            bad   = 0;
    int            mPtr, mCount;
    bit            mBad, mMis;
    logic [31:0]   img  [CAP];
    bit            imgV [CAP];

    imem_writer #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .count     (count),
        .full      (full),
        .bad_kind  (bad_kind),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; corrupt flips bit 0 on the read path only.
    always @(posedge clk) begin
        if (mem_we) memArr[mem_addr] <= mem_wdata;
        mem_rdata <= memArr[mem_addr] ^ {31'b0, corrupt};
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the ISA field layout, built with shifts and masks.
    function automatic logic [31:0] encRef(input logic [2:0] k, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [12:0] im);
        logic [31:0] i, dd, a, b, f3, f7;
        i  = {19'b0, im};
        dd = {27'b0, d};
        a  = {27'b0, s1};
        b  = {27'b0, s2};
        f3 = (k == 3'd5) ? 32'd7 : (k == 3'd6) ? 32'd6 : 32'd0;
        f7 = (k == 3'd4) ? 32'd32 : 32'd0;
        case (k)
            3'd0: return ((i & 32'hFFF) << 20) | (a << 15) | (32'd2 << 12) | (dd << 7) | 32'h03;
            3'd1: return (((i >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (32'd2 << 12)
                         | ((i & 32'h1F) << 7) | 32'h23;
            3'd2: return (((i >> 12) & 32'd1) << 31) | (((i >> 5) & 32'h3F) << 25) | (b << 20)
                         | (a << 15) | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'd1) << 7)
                         | 32'h63;
            3'd7: return 32'd0;
            default: return (f7 << 25) | (b << 20) | (a << 15) | (f3 << 12) | (dd << 7) | 32'h33;
        endcase
    endfunction

    task automatic restChecks(input string tag);
        check({tag, "_count"}, 32'(count), 32'(mCount));
        check({tag, "_full"}, {31'b0, full}, {31'b0, (mCount == CAP)});
        check({tag, "_ready"}, {31'b0, in_ready}, {31'b0, (mCount != CAP)});
        check({tag, "_addr"}, 32'(mem_addr), 32'(mPtr));
        check({tag, "_bad"}, {31'b0, bad_kind}, {31'b0, mBad});
        check({tag, "_mis"}, {31'b0, mismatch}, {31'b0, mMis});
    endtask

    // Called at negedge+1; returns at negedge+1 once the request has fully retired.
    task automatic send(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [12:0] im,
                        input logic [31:0] expW, input string tag);
        bit acc = 1'b0;
        kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
        for (int w = 0; w < 8 && !acc; w++) begin
            if (in_ready) acc = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check({tag, "_accept"}, {31'b0, acc}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (!acc) return;
        if (k == 3'd7) begin
            mBad = 1'b1;
            check({tag, "_noWe"}, {31'b0, mem_we}, 32'd0);
            restChecks(tag);
            return;
        end
        check({tag, "_we"}, {31'b0, mem_we}, 32'd1);
        check({tag, "_waddr"}, 32'(mem_addr), 32'(mPtr));
        check({tag, "_wdata"}, mem_wdata, expW);
        check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
        img[mPtr]  = expW;
        imgV[mPtr] = 1'b1;
        mPtr   = (mPtr + 1) % CAP;
        mCount = mCount + 1;
        if (RB) begin
            @(negedge clk); #1;
            check({tag, "_chkAddr"}, 32'(mem_addr), 32'((mPtr + CAP - 1) % CAP));
            check({tag, "_chkWe"}, {31'b0, mem_we}, 32'd0);
            @(negedge clk); #1;
            check({tag, "_cmpBusy"}, {31'b0, in_ready}, 32'd0);
            if (corrupt) mMis = 1'b1;
        end
        @(negedge clk); #1;
        restChecks(tag);
    endtask

    task automatic doClr(input string tag);
        clr = 1'b1;
        #1;
        check({tag, "_clrBlock"}, {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        mPtr = 0; mCount = 0; mBad = 1'b0;
        restChecks(tag);
    endtask

    initial begin
        logic [2:0]  rk;
        logic [4:0]  rdv, r1, r2;
        logic [12:0] ri;
        bit          seen;
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
        kind = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        mPtr = 0; mCount = 0; mBad = 1'b0; mMis = 1'b0;
        for (int a = 0; a < CAP; a++) imgV[a] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        restChecks("rst");
        reset = 1'b0;
        @(negedge clk); #1;

        send(3'd0, 5'd5, 5'd2, 5'd0, 13'd8, 32'h00812283, "lw");
        doClr("clr1");
        send(3'd1, 5'd0, 5'd2, 5'd6, 13'd12, 32'h00612623, "sw");
        send(3'd2, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3, "beq");
        send(3'd3, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, "add");
        send(3'd4, 5'd3, 5'd1, 5'd2, 13'd0, 32'h402081B3, "sub");

        // Fifth request while full must never be taken.
        in_valid = 1'b1; kind = 3'd5; seen = 1'b0;
        repeat (6) begin
            if (in_ready) seen = 1'b1;
            @(negedge clk); #1;
        end
        check("full_blocks", {31'b0, seen}, 32'd0);
        check("full_count", 32'(count), 32'(CAP));
        doClr("clrHeld");
        send(3'd6, 5'd9, 5'd4, 5'd7, 13'd0, encRef(3'd6, 5'd9, 5'd4, 5'd7, 13'd0), "afterClr");

        send(3'd7, 5'd1, 5'd1, 5'd1, 13'd1, 32'd0, "illegal");
        doClr("clrBad");

        for (int n = 0; n < 40; n++) begin
            if (mCount == CAP || $urandom_range(0, 7) == 0) begin
                doClr("rndClr");
            end else begin
                rk  = 3'($urandom_range(0, 7));
                rdv = 5'($urandom_range(0, 31));
                r1  = 5'($urandom_range(0, 31));
                r2  = 5'($urandom_range(0, 31));
                ri  = 13'($urandom_range(0, 8191));
                send(rk, rdv, r1, r2, ri, encRef(rk, rdv, r1, r2, ri), "rnd");
            end
        end

        doClr("preRb");
        corrupt = 1'b1;
        send(3'd5, 5'd8, 5'd3, 5'd4, 13'd0, encRef(3'd5, 5'd8, 5'd3, 5'd4, 13'd0), "corrupt");
        corrupt = 1'b0;
        doClr("postRb");
        check("mis_kept", {31'b0, mismatch}, {31'b0, RB});

        // Reset asserted during the WRITE cycle.
        kind = 3'd3; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = '0; in_valid = 1'b1;
        #1;
        check("rmw_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rmw_we", {31'b0, mem_we}, 32'd1);
        img[mPtr] = encRef(3'd3, 5'd1, 5'd2, 5'd3, 13'd0);
        imgV[mPtr] = 1'b1;
        reset = 1'b1;
        @(negedge clk); #1;
        mPtr = 0; mCount = 0; mBad = 1'b0; mMis = 1'b0;
        check("rmw_we0", {31'b0, mem_we}, 32'd0);
        check("rmw_wdata0", mem_wdata, 32'd0);
        restChecks("rmw");
        reset = 1'b0;
        @(negedge clk); #1;

        for (int a = 0; a < CAP; a++) begin
            if (imgV[a]) check("image", memArr[a], img[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
